// File: rtl/counter_sequencer.sv
// Prescaled up-counter with a run/pause/done sequencer, optional auto-reload
// and a saturating wrap counter. All outputs are registered.
module counter_sequencer #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  auto_reload,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  paused,
  output logic                  done,
  output logic [7:0]            wraps
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

  state_e                state_q;
  logic [WIDTH-1:0]      count_q;
  logic [WIDTH-1:0]      limit_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  auto_q;
  logic                  busy_q;
  logic                  paused_q;
  logic                  done_q;
  logic [7:0]            wraps_q;

  logic                  step_d;
  logic [WIDTH-1:0]      count_inc_d;
  logic [7:0]            wraps_inc_d;

  always_comb begin
    step_d      = (presc_q == prescale_q);
    count_inc_d = count_q + 1'b1;
    wraps_inc_d = (wraps_q == 8'hFF) ? wraps_q : wraps_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      limit_q    <= '0;
      presc_q    <= '0;
      prescale_q <= '0;
      auto_q     <= 1'b0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
      done_q     <= 1'b0;
      wraps_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (abort) begin
            state_q  <= IDLE;
            count_q  <= '0;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
          end else if (start) begin
            limit_q    <= limit;
            prescale_q <= prescale;
            auto_q     <= auto_reload;
            count_q    <= '0;
            presc_q    <= '0;
            wraps_q    <= '0;
            paused_q   <= 1'b0;
            // A zero limit is already reached: finish without running.
            if (limit != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (abort) begin
            state_q  <= IDLE;
            count_q  <= '0;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
          end else if (pause) begin
            state_q  <= PAUSE;
            paused_q <= 1'b1;
          end else if (step_d) begin
            presc_q <= '0;
            if (count_q < limit_q) begin
              count_q <= count_inc_d;
              if (count_inc_d == limit_q) begin
                done_q <= 1'b1;
                if (!auto_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                end
              end
            end else begin
              // Only reachable with auto-reload: the step after hitting limit wraps.
              count_q <= '0;
              wraps_q <= wraps_inc_d;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end

        PAUSE: begin
          if (abort) begin
            state_q  <= IDLE;
            count_q  <= '0;
            presc_q  <= '0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
          end else if (!pause) begin
            state_q  <= RUN;
            paused_q <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign count  = count_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign done   = done_q;
  assign wraps  = wraps_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: each stimulus cycle queues the
// expected post-edge outputs; a monitor pops and compares after every edge.
module tb_counter_sequencer;

  localparam int unsigned W  = 5;
  localparam int unsigned PW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          pause;
  logic          abort;
  logic [W-1:0]  limit;
  logic [PW-1:0] prescale;
  logic          auto_reload;
  logic [W-1:0]  count;
  logic          busy;
  logic          paused;
  logic          done;
  logic [7:0]    wraps;

  typedef struct {
    string        name;
    logic [W-1:0] count;
    logic         busy;
    logic         paused;
    logic         done;
    logic [7:0]   wraps;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  counter_sequencer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .limit       (limit),
    .prescale    (prescale),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .paused      (paused),
    .done        (done),
    .wraps       (wraps)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Queue the outputs expected after the coming rising edge, then move to
  // the next falling edge where the following inputs are driven.
  task automatic tick(input string nm, input int c, input bit b, input bit p,
                      input bit d, input int w);
    exp_t e;
    e.name   = nm;
    e.count  = W'(c);
    e.busy   = b;
    e.paused = p;
    e.done   = d;
    e.wraps  = 8'(w);
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (count !== e.count || busy !== e.busy || paused !== e.paused ||
            done !== e.done || wraps !== e.wraps) begin
          errors++;
          $display("FAIL %s: got count=%0d busy=%0b paused=%0b done=%0b wraps=%0d, expected count=%0d busy=%0b paused=%0b done=%0b wraps=%0d",
                   e.name, count, busy, paused, done, wraps,
                   e.count, e.busy, e.paused, e.done, e.wraps);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    limit = '0; prescale = '0; auto_reload = 1'b0;
    tick("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // limit=5, prescale=0, one-shot
    limit = 5; prescale = 0; auto_reload = 1'b0; start = 1'b1;
    tick("a_start", 0, 1, 0, 0, 0);
    start = 1'b0;
    tick("a_c1", 1, 1, 0, 0, 0);
    tick("a_c2", 2, 1, 0, 0, 0);
    tick("a_c3", 3, 1, 0, 0, 0);
    tick("a_c4", 4, 1, 0, 0, 0);
    tick("a_c5_done", 5, 0, 0, 1, 0);
    tick("a_hold1", 5, 0, 0, 0, 0);
    tick("a_hold2", 5, 0, 0, 0, 0);

    // limit=2, prescale=3, restart from DONE; a start mid-run is ignored
    limit = 2; prescale = 3; start = 1'b1;
    tick("b_start", 0, 1, 0, 0, 0);
    start = 1'b0;
    tick("b_e1", 0, 1, 0, 0, 0);
    start = 1'b1; limit = 7; prescale = 0;
    tick("b_e2_ign", 0, 1, 0, 0, 0);
    start = 1'b0;
    tick("b_e3", 0, 1, 0, 0, 0);
    tick("b_e4", 1, 1, 0, 0, 0);
    tick("b_e5", 1, 1, 0, 0, 0);
    tick("b_e6", 1, 1, 0, 0, 0);
    tick("b_e7", 1, 1, 0, 0, 0);
    tick("b_e8_done", 2, 0, 0, 1, 0);
    tick("b_hold", 2, 0, 0, 0, 0);

    // limit=3, auto-reload, run past wraps saturation
    limit = 3; prescale = 0; auto_reload = 1'b1; start = 1'b1;
    tick("c_start", 0, 1, 0, 0, 0);
    start = 1'b0;
    for (int n = 1; n <= 1040; n++)
      tick("c_wrap", n % 4, 1, 0, (n % 4) == 3, (n / 4 > 255) ? 255 : n / 4);
    abort = 1'b1;
    tick("c_abort_keeps_wraps", 0, 0, 0, 0, 255);
    abort = 1'b0; rst = 1'b1;
    tick("c_rst_clears_wraps", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // pause for three cycles at count=2, then abort from PAUSE
    limit = 5; prescale = 0; auto_reload = 1'b0; start = 1'b1;
    tick("d_start", 0, 1, 0, 0, 0);
    start = 1'b0;
    tick("d_c1", 1, 1, 0, 0, 0);
    tick("d_c2", 2, 1, 0, 0, 0);
    pause = 1'b1;
    tick("d_pause1", 2, 1, 1, 0, 0);
    tick("d_pause2", 2, 1, 1, 0, 0);
    tick("d_pause3", 2, 1, 1, 0, 0);
    pause = 1'b0;
    tick("d_release", 2, 1, 0, 0, 0);
    tick("d_c3", 3, 1, 0, 0, 0);
    pause = 1'b1;
    tick("d_pause_c3", 3, 1, 1, 0, 0);
    abort = 1'b1;
    tick("d_abort_pause", 0, 0, 0, 0, 0);
    abort = 1'b0;
    tick("d_pause_idle", 0, 0, 0, 0, 0);
    pause = 1'b0;

    // start+abort in DONE stays IDLE
    limit = 1; start = 1'b1;
    tick("e_start", 0, 1, 0, 0, 0);
    start = 1'b0;
    tick("e_done", 1, 0, 0, 1, 0);
    start = 1'b1; abort = 1'b1;
    tick("e_start_abort", 0, 0, 0, 0, 0);
    start = 1'b0; abort = 1'b0;
    tick("e_idle", 0, 0, 0, 0, 0);

    // reset mid-run at count=4 overrides other inputs
    limit = 9; start = 1'b1;
    tick("f_start", 0, 1, 0, 0, 0);
    start = 1'b0;
    tick("f_c1", 1, 1, 0, 0, 0);
    tick("f_c2", 2, 1, 0, 0, 0);
    tick("f_c3", 3, 1, 0, 0, 0);
    tick("f_c4", 4, 1, 0, 0, 0);
    rst = 1'b1; start = 1'b1; pause = 1'b1;
    tick("f_rst", 0, 0, 0, 0, 0);
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    tick("f_after_rst", 0, 0, 0, 0, 0);

    // limit=0 goes straight to DONE with a single done pulse
    limit = 0; start = 1'b1;
    tick("g_zero_done", 0, 0, 0, 1, 0);
    start = 1'b0;
    tick("g_hold1", 0, 0, 0, 0, 0);
    tick("g_hold2", 0, 0, 0, 0, 0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the count/limit width in bits.
REQ-002 The block SHALL have parameter PRESCALE_W, default 4, giving the prescale field width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, the run request, sampled in IDLE/DONE only.
REQ-006 The block SHALL have port pause, input, 1, a level-sensitive freeze request.
REQ-007 The block SHALL have port abort, input, 1, which cancels the run and returns to IDLE.
REQ-008 The block SHALL have port limit, input, WIDTH, the terminal count, latched at start.
REQ-009 The block SHALL have port prescale, input, PRESCALE_W; the count steps every prescale+1 cycles; latched at start.
REQ-010 The block SHALL have port auto_reload, input, 1; 1 means wrap and keep running; latched at start.
REQ-011 The block SHALL have port count, output, WIDTH, the current count (registered).
REQ-012 The block SHALL have port busy, output, 1, high in RUN or PAUSE (registered).
REQ-013 The block SHALL have port paused, output, 1, high in PAUSE (registered).
REQ-014 The block SHALL have port done, output, 1, a one-cycle pulse when count reaches the limit (registered).
REQ-015 The block SHALL have port wraps, output, 8, the saturating count of auto-reload wraps (registered).

Function
REQ-016 The FSM SHALL have states IDLE, RUN, PAUSE, DONE.
REQ-017 Priority per edge SHALL be rst > abort > pause > start/step.
REQ-018 start in IDLE/DONE with limit!=0 SHALL latch limit, prescale, auto_reload, clear count, prescaler and wraps, and enter RUN at that edge.
REQ-019 start in IDLE/DONE with limit==0 SHALL enter DONE, pulse done, and hold count=0.
REQ-020 start in RUN/PAUSE SHALL be ignored, with no re-latch.
REQ-021 In RUN, the prescaler SHALL increment each cycle; when it equals latched prescale it SHALL clear and a step occurs.
REQ-022 A step with count<limit SHALL set count to count+1; if the result equals limit, done SHALL be 1 the following cycle only.
REQ-023 If count reaches limit with auto_reload=0, the FSM SHALL enter DONE at that same edge, and count SHALL hold at limit.
REQ-024 With auto_reload=1, the step at count==limit SHALL set count to 0 and increment wraps, saturating at 255; the FSM SHALL stay in RUN.
REQ-025 count SHALL never exceed the latched limit; no arithmetic overflow SHALL occur (limit is at most 2^WIDTH-1).
REQ-026 pause=1 in RUN SHALL enter PAUSE; a step due that cycle SHALL be suppressed and the prescaler SHALL freeze.
REQ-027 In PAUSE, count and prescaler SHALL hold; pause=0 SHALL return to RUN and resume from the frozen prescaler value.
REQ-028 pause in IDLE/DONE SHALL have no effect.
REQ-029 abort in RUN/PAUSE/DONE SHALL enter IDLE, set count=0 and prescaler=0, suppress done, and keep wraps.
REQ-030 abort together with start in IDLE/DONE SHALL leave the FSM in IDLE.
REQ-031 DONE SHALL persist until start (restart) or abort.

Reset
REQ-032 When rst=1 at an edge, the block SHALL enter IDLE with count=0, busy=0, paused=0, done=0, wraps=0, prescaler=0 and latched config=0, regardless of other inputs or the current state, including mid-run.

Verification
REQ-033 The bench SHALL cover: limit=5, prescale=0, auto=0, start at edge E0 -> busy=1 after E0; count 1..5 after E1..E5; done=1 only in the cycle after E5; DONE; count holds 5.
REQ-034 The bench SHALL cover: limit=2, prescale=3 -> count=1 after E4, count=2 after E8, done once, then DONE.
REQ-035 The bench SHALL cover: limit=3, auto=1, prescale=0 -> count 1,2,3,0,1,...; done pulses each time count=3; wraps increments on each 3->0 and saturates at 255.
REQ-036 The bench SHALL cover: pause held 3 cycles when count=2 (prescale=0) -> paused=1, count stays 2, then 3 on the first RUN edge after release.
REQ-037 The bench SHALL cover: abort in PAUSE -> IDLE, count=0, busy=0, no done; start+abort in DONE -> remains IDLE.
REQ-038 The bench SHALL cover: rst asserted at count=4 in RUN -> all outputs 0 next cycle; also limit=0 start -> DONE, done pulse, count=0.
